// File: rtl/virtio_available_ring_fetcher.sv
// virtio_available_ring_fetcher
//   Request generator in front of the available-ring reader. A doorbell makes
//   it poll the avail ring idx field; the number of new entries since
//   last_avail_idx is then fetched as READ_IDS requests that never cross the
//   ring end and never exceed MAX_BURST IDs. After the last chunk the idx
//   field is polled again to pick up entries posted in the meantime.
//
// Ports
//   aclk, areset      clock, synchronous active-high reset
//   enable            queue enabled; dropping it rewinds the fetcher
//   queue_size        ring entries (power of two), stable while enabled
//   notify            doorbell pulse
//   request_*         request to the ring reader (valid/ready, registered)
//   idx_valid, idx    avail idx value returned by the ring reader
//   last_avail_idx    next avail entry to fetch (free-running 16-bit)
//   busy              fetcher not idle
//   error             sticky: ring reported more new entries than it holds
module virtio_available_ring_fetcher #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        enable,
    input  logic [15:0] queue_size,
    input  logic        notify,
    output logic        request_valid,
    input  logic        request_ready,
    output logic [1:0]  request_type,
    output logic [15:0] request_length,
    output logic [15:0] request_offset,
    input  logic        idx_valid,
    input  logic [15:0] idx,
    output logic [15:0] last_avail_idx,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_IDX,
        S_WAIT_IDX,
        S_ISSUE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        REQ_READ_IDS = 2'd0,
        REQ_READ_IDX = 2'd1
    } request_type_t;

    localparam logic [15:0] BURST_LIMIT = 16'(MAX_BURST);

    state_t        state_q, state_d;
    logic [15:0]   pending_q, pending_d;
    logic [15:0]   last_q, last_d;
    logic          notify_latch_q, notify_latch_d;
    logic          error_q, error_d;
    logic          req_valid_q, req_valid_d;
    request_type_t req_type_q, req_type_d;
    logic [15:0]   req_len_q, req_len_d;
    logic [15:0]   req_off_q, req_off_d;

    logic [15:0]   head;
    logic [15:0]   room;
    logic [15:0]   chunk_len;
    logic [15:0]   diff;
    logic [15:0]   pending_after;

    // Chunk size: bounded by what is left, the burst limit and the distance
    // to the ring end (so a wrapping fetch is always split in two).
    always_comb begin
        head = last_q & (queue_size - 16'd1);
        room = queue_size - head;
        chunk_len = pending_q;
        if (chunk_len > BURST_LIMIT) begin
            chunk_len = BURST_LIMIT;
        end
        if (chunk_len > room) begin
            chunk_len = room;
        end
        diff          = idx - last_q;
        pending_after = pending_q - req_len_q;
    end

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        last_d         = last_q;
        notify_latch_d = notify_latch_q;
        error_d        = error_q;
        req_valid_d    = req_valid_q;
        req_type_d     = req_type_q;
        req_len_d      = req_len_q;
        req_off_d      = req_off_q;

        if (notify && enable) begin
            notify_latch_d = 1'b1;
        end

        if (!enable) begin
            // A request already offered stays on the bus until accepted;
            // only then does the queue rewind.
            if (!(req_valid_q && !request_ready)) begin
                state_d        = S_IDLE;
                req_valid_d    = 1'b0;
                pending_d      = '0;
                last_d         = '0;
                error_d        = 1'b0;
                notify_latch_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (notify_latch_q || notify) begin
                        state_d        = S_REQ_IDX;
                        notify_latch_d = 1'b0;
                    end
                end
                S_REQ_IDX: begin
                    if (!req_valid_q) begin
                        req_valid_d = 1'b1;
                        req_type_d  = REQ_READ_IDX;
                        req_len_d   = 16'd1;
                        req_off_d   = '0;
                    end else if (request_ready) begin
                        req_valid_d = 1'b0;
                        state_d     = S_WAIT_IDX;
                    end
                end
                S_WAIT_IDX: begin
                    if (idx_valid) begin
                        if (diff == '0) begin
                            state_d = S_IDLE;
                        end else if (diff > queue_size) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                        end else begin
                            pending_d = diff;
                            state_d   = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!req_valid_q) begin
                        req_valid_d = 1'b1;
                        req_type_d  = REQ_READ_IDS;
                        req_len_d   = chunk_len;
                        req_off_d   = head;
                    end else if (request_ready) begin
                        req_valid_d = 1'b0;
                        last_d      = last_q + req_len_q;
                        pending_d   = pending_after;
                        if (pending_after == '0) begin
                            state_d = S_REQ_IDX;
                        end
                    end
                end
                S_ERROR: begin
                    req_valid_d = 1'b0;
                end
                default: begin
                    state_d     = S_IDLE;
                    req_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            last_q         <= '0;
            notify_latch_q <= 1'b0;
            error_q        <= 1'b0;
            req_valid_q    <= 1'b0;
            req_type_q     <= REQ_READ_IDS;
            req_len_q      <= '0;
            req_off_q      <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            last_q         <= last_d;
            notify_latch_q <= notify_latch_d;
            error_q        <= error_d;
            req_valid_q    <= req_valid_d;
            req_type_q     <= req_type_d;
            req_len_q      <= req_len_d;
            req_off_q      <= req_off_d;
        end
    end

    assign request_valid  = req_valid_q;
    assign request_type   = req_type_q;
    assign request_length = req_len_q;
    assign request_offset = req_off_q;
    assign last_avail_idx = last_q;
    assign busy           = (state_q != S_IDLE);
    assign error          = error_q;

endmodule

// File: tb/tb_virtio_available_ring_fetcher.sv
// Testbench for virtio_available_ring_fetcher: a scoreboard of expected
// requests is filled from a reference model whenever a poll is triggered and
// drained as the DUT hands requests over; state outputs are checked against
// constants after each scenario.
module tb_virtio_available_ring_fetcher;

    localparam int unsigned MAX_BURST = 16;

    logic        aclk;
    logic        areset;
    logic        enable;
    logic [15:0] queue_size;
    logic        notify;
    logic        request_valid;
    logic        request_ready;
    logic [1:0]  request_type;
    logic [15:0] request_length;
    logic [15:0] request_offset;
    logic        idx_valid;
    logic [15:0] idx;
    logic [15:0] last_avail_idx;
    logic        busy;
    logic        error;

    virtio_available_ring_fetcher #(.MAX_BURST(MAX_BURST)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .queue_size    (queue_size),
        .notify        (notify),
        .request_valid (request_valid),
        .request_ready (request_ready),
        .request_type  (request_type),
        .request_length(request_length),
        .request_offset(request_offset),
        .idx_valid     (idx_valid),
        .idx           (idx),
        .last_avail_idx(last_avail_idx),
        .busy          (busy),
        .error         (error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]  typ;
        logic [15:0] len;
        logic [15:0] off;
    } req_t;

    req_t        exp_q[$];
    int unsigned n_compared;
    int unsigned n_mismatched;
    logic [15:0] model_last;
    logic [15:0] ring_idx;
    bit          rand_ready;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model of one poll: READ_IDX, then the READ_IDS chunks, then
    // the re-poll (which sees the same idx and finds nothing new).
    function automatic void push_poll(input logic [15:0] target, input int unsigned qs);
        logic [15:0] d;
        int unsigned pending;
        int unsigned head;
        int unsigned len;
        exp_q.push_back({2'd1, 16'd1, 16'd0});
        d = target - model_last;
        pending = d;
        if (pending == 0 || pending > qs) return;
        while (pending > 0) begin
            head = int'(model_last) % qs;
            len = pending;
            if (len > MAX_BURST) len = MAX_BURST;
            if (len > qs - head) len = qs - head;
            exp_q.push_back({2'd0, 16'(len), 16'(head)});
            model_last = model_last + 16'(len);
            pending = pending - len;
        end
        exp_q.push_back({2'd1, 16'd1, 16'd0});
    endfunction

    task automatic pulse_notify();
        @(negedge aclk);
        notify = 1'b1;
        @(negedge aclk);
        notify = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_valid"},  32'(request_valid),  32'd0);
        check_eq({pfx, "_type"},   32'(request_type),   32'd0);
        check_eq({pfx, "_length"}, 32'(request_length), 32'd0);
        check_eq({pfx, "_offset"}, 32'(request_offset), 32'd0);
        check_eq({pfx, "_last"},   32'(last_avail_idx), 32'd0);
        check_eq({pfx, "_busy"},   32'(busy),           32'd0);
        check_eq({pfx, "_error"},  32'(error),          32'd0);
    endtask

    // Acts as the ring reader: accepts requests (optionally with random
    // back-pressure), answers READ_IDX with ring_idx, scores every handshake.
    task automatic run(input int unsigned max_cycles, input bit notify_on_ids);
        int unsigned cycles = 0;
        bit   idx_due  = 1'b0;
        bit   stalled  = 1'b0;
        bit   notified = 1'b0;
        bit   done     = 1'b0;
        req_t prev = '0;
        req_t cur;
        req_t e;
        while (!done) begin
            idx_valid = idx_due;
            idx       = ring_idx;
            idx_due   = 1'b0;
            notify    = 1'b0;
            cur = {request_type, request_length, request_offset};
            if (request_valid && stalled) begin
                check_eq("stall_stable", 32'(cur), 32'(prev));
            end
            request_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (request_valid && request_ready) begin
                check_eq("req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("req_type",   32'(request_type),   32'(e.typ));
                    check_eq("req_length", 32'(request_length), 32'(e.len));
                    check_eq("req_offset", 32'(request_offset), 32'(e.off));
                end
                if (request_type == 2'd1) idx_due = 1'b1;
                if (notify_on_ids && request_type == 2'd0 && !notified) begin
                    notify   = 1'b1;
                    notified = 1'b1;
                end
                stalled = 1'b0;
            end else begin
                stalled = request_valid;
            end
            prev = cur;
            if (exp_q.size() == 0 && (!busy || error) && !idx_due && !notify) begin
                done = 1'b1;
            end
            cycles++;
            if (!done && cycles > max_cycles) begin
                check_eq("run_timeout", cycles, max_cycles);
                done = 1'b1;
            end
            @(negedge aclk);
        end
        idx_valid     = 1'b0;
        notify        = 1'b0;
        request_ready = 1'b0;
        check_eq("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic restart_queue(input logic [15:0] qs);
        @(negedge aclk);
        enable = 1'b0;
        repeat (2) @(negedge aclk);
        queue_size = qs;
        enable     = 1'b1;
        model_last = '0;
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        areset        = 1'b1;
        enable        = 1'b0;
        queue_size    = 16'd8;
        notify        = 1'b0;
        request_ready = 1'b0;
        idx_valid     = 1'b0;
        idx           = '0;
        model_last    = '0;
        ring_idx      = '0;
        rand_ready    = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        check_reset_outputs("reset");

        // qs=8: five new entries in one chunk
        enable = 1'b1;
        ring_idx = 16'd5;
        push_poll(ring_idx, 8);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("qs8_last5", 32'(last_avail_idx), 32'd5);
        check_eq("qs8_idle", 32'(busy), 32'd0);

        // advance to 6, then a fetch crossing the ring end: 2@6, 3@0
        ring_idx = 16'd6;
        push_poll(ring_idx, 8);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("qs8_last6", 32'(last_avail_idx), 32'd6);
        ring_idx = 16'd11;
        push_poll(ring_idx, 8);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("wrap_last11", 32'(last_avail_idx), 32'd11);

        // disabling rewinds; qs=256 splits 40 at burst limit: 16,16,8
        restart_queue(16'd256);
        check_eq("rewind_last", 32'(last_avail_idx), 32'd0);
        ring_idx = 16'd40;
        push_poll(ring_idx, 256);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("burst_last40", 32'(last_avail_idx), 32'd40);

        // walk last_avail_idx to 0xFFFE, then fetch across the 16-bit wrap
        restart_queue(16'd32768);
        rand_ready = 1'b0;
        ring_idx = 16'h8000;
        push_poll(ring_idx, 32768);
        pulse_notify();
        run(20000, 1'b0);
        check_eq("full_ring_last", 32'(last_avail_idx), 32'h8000);
        ring_idx = 16'hFFFE;
        push_poll(ring_idx, 32768);
        pulse_notify();
        run(20000, 1'b0);
        check_eq("pre_wrap_last", 32'(last_avail_idx), 32'hFFFE);
        rand_ready = 1'b1;
        ring_idx = 16'h0002;
        push_poll(ring_idx, 32768);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("wrap16_last", 32'(last_avail_idx), 32'h0002);

        // idx too far ahead: error, no READ_IDS; cleared by disable
        restart_queue(16'd8);
        ring_idx = 16'd9;
        push_poll(ring_idx, 8);
        pulse_notify();
        run(2000, 1'b0);
        check_eq("err_set", 32'(error), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge aclk);
        check_eq("err_no_req", 32'(request_valid), 32'd0);
        enable = 1'b0;
        @(negedge aclk);
        check_eq("err_cleared", 32'(error), 32'd0);
        check_eq("err_idle", 32'(busy), 32'd0);

        // reset pulse while a request is stalled
        enable = 1'b1;
        model_last = '0;
        ring_idx = 16'd5;
        pulse_notify();
        for (int i = 0; i < 10 && !request_valid; i++) @(negedge aclk);
        check_eq("stall_valid", 32'(request_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            areset = (i == 2);
            if (i == 3) check_reset_outputs("midreset");
        end
        areset = 1'b0;

        // doorbell during ISSUE forces one extra poll
        restart_queue(16'd256);
        ring_idx = 16'd20;
        push_poll(ring_idx, 256);
        exp_q.push_back({2'd1, 16'd1, 16'd0});
        pulse_notify();
        run(2000, 1'b1);
        check_eq("extra_poll_last", 32'(last_avail_idx), 32'd20);
        check_eq("extra_poll_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
